change_collector: RTL and testbench
===================================

CHANGE_COLLECTOR -- requirements
Module: change_collector

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32, giving the number of COLLECT cycles without FIM before an error is declared.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to load expected and arm collection.
REQ-005 SHALL have port expected, input, 5, the change value in units, 0..31, sampled when start=1.
REQ-006 SHALL have port DEZ, input, 1, a ten-unit coin event, one coin per cycle high.
REQ-007 SHALL have port DOIS, input, 1, a two-unit coin event, one coin per cycle high.
REQ-008 SHALL have port FIM, input, 1, the dispenser end-of-change indication.
REQ-009 SHALL have port total, output, 5, the accumulated change value.
REQ-010 SHALL have port tens, output, 3, the count of DEZ coins, saturating at 7.
REQ-011 SHALL have port twos, output, 4, the count of DOIS coins, saturating at 15.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse when a verdict is issued.
REQ-013 SHALL have ports ok and err, output, 1 each, the verdict, held until the next start or reset.
REQ-014 SHALL have port state, output, 2, the current FSM state encoding.

Function
REQ-015 SHALL implement FSM states IDLE=0, COLLECT=1, CHECK=2, REPORT=3.
REQ-016 SHALL, in IDLE with start=1, clear total/tens/twos/ok/err, latch expected and enter COLLECT on the next edge.
REQ-017 SHALL, in COLLECT, add 10 per cycle with DEZ=1 and 2 per cycle with DOIS=1; both high in one cycle adds 12.
REQ-018 SHALL saturate total at 31 and set an internal overflow flag when a sum would exceed 31.
REQ-019 SHALL, in COLLECT with FIM=1, count that cycle's coins and enter CHECK on the same edge.
REQ-020 SHALL ignore DEZ, DOIS and FIM outside COLLECT.
REQ-021 SHALL, in CHECK, set ok=1 iff total==latched expected and no overflow and no order error (REQ-029), else set err=1; then enter REPORT.
REQ-022 SHALL assert done for exactly the one REPORT cycle, then return to IDLE.
REQ-023 SHALL ensure ok and err are never both 1.
REQ-024 SHALL, when TIMEOUT consecutive COLLECT cycles pass without FIM, set err=1 and go to REPORT, skipping CHECK.
REQ-025 SHALL, on start=1 during COLLECT, restart collection: clear counters, timer and overflow, and reload expected. Start in CHECK/REPORT is ignored.
REQ-026 SHALL give a latency of exactly 2 clock edges from FIM sampled to done=1.

Reset
REQ-027 SHALL, on reset=0 and independent of clock, force state=IDLE, total=0, tens=0, twos=0, done=0, ok=0, err=0, the timer and overflow to 0, and latched expected=0.
REQ-028 SHALL abandon any in-progress collection on reset without issuing done.

Configuration
REQ-029 SHALL, with COLLECTOR_GREEDY_CHECK_EN defined, flag an order error on any DEZ after a DOIS, or on a fifth DOIS coin, within one collection; this forces err at CHECK.
REQ-030 SHALL, without COLLECTOR_GREEDY_CHECK_EN, ignore coin order and count, so that only the value comparison decides ok.

Structure
REQ-031 SHALL place the state enum, the coin values TEN=10 and TWO=2, and the value width 5 in the shared package change_pkg.
REQ-032 SHALL contain one sub-module, collector_timer: a TIMEOUT-cycle counter with clear and enable inputs and an expired output.

Verification
REQ-033 SHALL test: start expected=2, one DOIS, FIM -> total=2, twos=1, ok=1, done a single pulse 2 edges after FIM.
REQ-034 SHALL test: expected=14; DEZ, DOIS, DOIS with FIM on the last -> total=14, tens=1, twos=2, ok=1.
REQ-035 SHALL test: expected=10; five DOIS, then FIM -> ok=1 without the macro; err=1 with COLLECTOR_GREEDY_CHECK_EN.
REQ-036 SHALL test: expected=30; four DEZ, then FIM -> total=31, err=1 (overflow).
REQ-037 SHALL test: start, then no FIM for 32 cycles -> err=1, done on the following cycle, state back to IDLE.
REQ-038 SHALL test: reset=0 mid-COLLECT after two DEZ -> all outputs 0 and state=IDLE immediately, with no done.

Source files
------------

// File: rtl/change_pkg.sv
`default_nettype none
// ============================================================================
// Module      : change_pkg
// Description : Shared definitions for the change collector: value width,
//               coin values, FSM state encoding and a widening coin adder.
// Revision    : 1.0  initial release
// ============================================================================
package change_pkg;

    localparam int VAL_W = 5;

    localparam logic [VAL_W-1:0] TEN     = 5'd10;
    localparam logic [VAL_W-1:0] TWO     = 5'd2;
    localparam logic [VAL_W-1:0] VAL_MAX = 5'd31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        REPORT  = 2'd3
    } state_t;

    // One bit wider than the value so that an overflow is visible.
    function automatic logic [VAL_W:0] coin_sum(input logic [VAL_W-1:0] acc,
                                                input logic             dez,
                                                input logic             dois);
        logic [VAL_W:0] s;
        s = {1'b0, acc};
        if (dez)
            s = s + {1'b0, TEN};
        if (dois)
            s = s + {1'b0, TWO};
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/collector_timer.sv
`default_nettype none
// ============================================================================
// Module      : collector_timer
// Description : Counts enabled cycles; expired is high during the TIMEOUT-th
//               consecutive enabled cycle since the last clear.
// Ports       : clock   - rising-edge clock
//               reset   - asynchronous active-low reset
//               clear   - synchronous clear (priority over enable)
//               enable  - count this cycle
//               expired - combinational, enabled cycle number TIMEOUT
// Revision    : 1.0  initial release
// ============================================================================
module collector_timer #(
    parameter int TIMEOUT = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    assign expired = enable && (count == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/change_collector.sv
`default_nettype none
// ============================================================================
// Module      : change_collector
// Description : Collects DEZ (10) and DOIS (2) coin events after a start,
//               and on FIM compares the accumulated value with the latched
//               expected change, issuing an ok/err verdict with a done pulse.
//               A collection with no FIM for TIMEOUT cycles ends in err.
// Ports       : clock, reset (async active-low), start, expected[4:0],
//               DEZ, DOIS, FIM  -> total[4:0], tens[2:0], twos[3:0],
//               done, ok, err, state[1:0]
// Config      : COLLECTOR_GREEDY_CHECK_EN - when defined, a DEZ after any
//               DOIS or a fifth DOIS in one collection forces err.
// Revision    : 1.0  initial release
// ============================================================================
module change_collector
    import change_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] expected,
    input  logic             DEZ,
    input  logic             DOIS,
    input  logic             FIM,
    output logic [VAL_W-1:0] total,
    output logic [2:0]       tens,
    output logic [3:0]       twos,
    output logic             done,
    output logic             ok,
    output logic             err,
    output logic [1:0]       state
);

    state_t           cur_state;
    state_t           next_state;
    logic [VAL_W-1:0] exp_latched;
    logic             overflow;
    logic             order_err;
    logic             load;
    logic             collecting;
    logic             timer_expired;
    logic [VAL_W:0]   sum;

    assign collecting = (cur_state == COLLECT);
    // A start in IDLE arms; a start in COLLECT restarts from scratch.
    assign load       = start && ((cur_state == IDLE) || collecting);
    assign sum        = coin_sum(total, DEZ, DOIS);
    assign done       = (cur_state == REPORT);
    assign state      = cur_state;

    // The timer only runs on FIM-free COLLECT cycles and restarts with any
    // start, so it measures consecutive cycles waiting for the dispenser.
    collector_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (!collecting || start),
        .enable  (collecting && !FIM),
        .expired (timer_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cur_state <= IDLE;
        else
            cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:    if (start) next_state = COLLECT;
            COLLECT: begin
                if (start)
                    next_state = COLLECT;
                else if (FIM)
                    next_state = CHECK;
                else if (timer_expired)
                    next_state = REPORT;
            end
            CHECK:   next_state = REPORT;
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            total       <= '0;
            tens        <= '0;
            twos        <= '0;
            ok          <= 1'b0;
            err         <= 1'b0;
            overflow    <= 1'b0;
            exp_latched <= '0;
        end else if (load) begin
            total       <= '0;
            tens        <= '0;
            twos        <= '0;
            ok          <= 1'b0;
            err         <= 1'b0;
            overflow    <= 1'b0;
            exp_latched <= expected;
        end else if (collecting) begin
            // Coins in the FIM cycle still count.
            if (sum > {1'b0, VAL_MAX}) begin
                total    <= VAL_MAX;
                overflow <= 1'b1;
            end else begin
                total    <= sum[VAL_W-1:0];
            end
            if (DEZ && (tens != 3'd7))
                tens <= tens + 3'd1;
            if (DOIS && (twos != 4'd15))
                twos <= twos + 4'd1;
            if (!FIM && timer_expired)
                err <= 1'b1;
        end else if (cur_state == CHECK) begin
            if ((total == exp_latched) && !overflow && !order_err)
                ok  <= 1'b1;
            else
                err <= 1'b1;
        end
    end

`ifdef COLLECTOR_GREEDY_CHECK_EN
    logic seen_dois;

    // twos saturates well above 4, so twos >= 4 with a DOIS marks coin five.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seen_dois <= 1'b0;
            order_err <= 1'b0;
        end else if (load) begin
            seen_dois <= 1'b0;
            order_err <= 1'b0;
        end else if (collecting) begin
            if (DOIS)
                seen_dois <= 1'b1;
            if ((DEZ && seen_dois) || (DOIS && (twos >= 4'd4)))
                order_err <= 1'b1;
        end
    end
`else
    assign order_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_change_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_collector
// Description : Self-checking bench for change_collector: reset, directed
//               value cases, restart, timeout, mid-collection reset and
//               randomized collections against a coin-counting model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_change_collector;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] expected;
    logic       DEZ;
    logic       DOIS;
    logic       FIM;
    logic [4:0] total;
    logic [2:0] tens;
    logic [3:0] twos;
    logic       done;
    logic       ok;
    logic       err;
    logic [1:0] state;

    int passed = 0;
    int checks = 0;

    always #5 clock = ~clock;

    change_collector #(
        .TIMEOUT (32)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .expected (expected),
        .DEZ      (DEZ),
        .DOIS     (DOIS),
        .FIM      (FIM),
        .total    (total),
        .tens     (tens),
        .twos     (twos),
        .done     (done),
        .ok       (ok),
        .err      (err),
        .state    (state)
    );

    // Reference: sum coin values as plain integers, count coins, apply the
    // order rules, then saturate only for the visible outputs.
    task automatic model(input int n, input logic [23:0] dz, input logic [23:0] dw,
                         input logic [4:0] exp_v, output int m_total, output int m_tens,
                         output int m_twos, output logic m_ok, output logic m_ord);
        int sum = 0;
        int nt  = 0;
        int nw  = 0;
        m_ord = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (dz[i]) begin
                if (nw > 0) m_ord = 1'b1;
                nt++;
                sum += 10;
            end
            if (dw[i]) begin
                nw++;
                if (nw == 5) m_ord = 1'b1;
                sum += 2;
            end
        end
        m_total = (sum > 31) ? 31 : sum;
        m_tens  = (nt > 7) ? 7 : nt;
        m_twos  = (nw > 15) ? 15 : nw;
        m_ok    = (sum <= 31) && (sum == int'(exp_v));
`ifdef COLLECTOR_GREEDY_CHECK_EN
        if (m_ord) m_ok = 1'b0;
`endif
    endtask

    // Stimulus driver only: applies a collection and reports what it saw.
    // Inputs outside COLLECT are driven with random junk.
    task automatic drive_collection(input logic [4:0] exp_v, input int n,
                                    input logic [23:0] dz, input logic [23:0] dw,
                                    output int lat, output logic [4:0] g_total,
                                    output logic [2:0] g_tens, output logic [3:0] g_twos,
                                    output logic g_ok, output logic g_err,
                                    output logic [1:0] g_mid_state, output logic g_done_after,
                                    output logic g_ok_after, output logic g_err_after,
                                    output logic [1:0] g_state_after);
        @(negedge clock);
        start    = 1'b1;
        expected = exp_v;
        DEZ      = 1'($urandom_range(0, 1));
        DOIS     = 1'($urandom_range(0, 1));
        FIM      = 1'($urandom_range(0, 1));
        @(negedge clock);
        start       = 1'b0;
        g_mid_state = state;
        for (int i = 0; i < n; i++) begin
            DEZ  = dz[i];
            DOIS = dw[i];
            FIM  = (i == n - 1);
            @(negedge clock);
        end
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin
            DEZ  = 1'($urandom_range(0, 1));
            DOIS = 1'($urandom_range(0, 1));
            FIM  = 1'($urandom_range(0, 1));
            @(negedge clock);
            lat++;
        end
        g_total = total;
        g_tens  = tens;
        g_twos  = twos;
        g_ok    = ok;
        g_err   = err;
        DEZ  = 1'b0;
        DOIS = 1'b0;
        FIM  = 1'b0;
        @(negedge clock);
        g_done_after  = done;
        g_ok_after    = ok;
        g_err_after   = err;
        g_state_after = state;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        expected = 5'd0;
        DEZ      = 1'b0;
        DOIS     = 1'b0;
        FIM      = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({state, total, tens, twos, done, ok, err} !== 17'd0)
            $display("FAIL reset_outputs: got state=%0d total=%0d tens=%0d twos=%0d done=%b ok=%b err=%b, want all 0",
                     state, total, tens, twos, done, ok, err);
        else passed++;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (state !== 2'd0 || done !== 1'b0)
            $display("FAIL reset_release: got state=%0d done=%b, want 0 0", state, done);
        else passed++;
    endtask

    task automatic test_directed();
        string      t_name [5] = '{"one_dois", "dez_dois_dois", "five_dois", "overflow", "saturate"};
        logic [4:0] t_exp  [5] = '{5'd2, 5'd14, 5'd10, 5'd30, 5'd0};
        int         t_n    [5] = '{1, 3, 6, 5, 16};
        logic [23:0] t_dz  [5] = '{24'h0, 24'h1, 24'h0, 24'hF, 24'hFF};
        logic [23:0] t_dw  [5] = '{24'h1, 24'h6, 24'h1F, 24'h0, 24'hFFFF};
        logic [4:0] w_total[5] = '{5'd2, 5'd14, 5'd10, 5'd31, 5'd31};
        logic [2:0] w_tens [5] = '{3'd1 - 3'd1, 3'd1, 3'd0, 3'd4, 3'd7};
        logic [3:0] w_twos [5] = '{4'd1, 4'd2, 4'd5, 4'd0, 4'd15};
`ifdef COLLECTOR_GREEDY_CHECK_EN
        logic       w_ok   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
        logic       w_ok   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        int lat;
        logic [4:0] g_total;
        logic [2:0] g_tens;
        logic [3:0] g_twos;
        logic g_ok, g_err, g_done_after, g_ok_after, g_err_after;
        logic [1:0] g_mid, g_state_after;
        for (int k = 0; k < 5; k++) begin
            drive_collection(t_exp[k], t_n[k], t_dz[k], t_dw[k], lat, g_total, g_tens, g_twos,
                             g_ok, g_err, g_mid, g_done_after, g_ok_after, g_err_after, g_state_after);
            checks++;
            if (g_mid !== 2'd1) $display("FAIL %s_collect_state: got %0d, want 1", t_name[k], g_mid);
            else passed++;
            checks++;
            if (lat != 2) $display("FAIL %s_latency: got %0d edges, want 2", t_name[k], lat);
            else passed++;
            checks++;
            if (g_total !== w_total[k]) $display("FAIL %s_total: got %0d, want %0d", t_name[k], g_total, w_total[k]);
            else passed++;
            checks++;
            if (g_tens !== w_tens[k]) $display("FAIL %s_tens: got %0d, want %0d", t_name[k], g_tens, w_tens[k]);
            else passed++;
            checks++;
            if (g_twos !== w_twos[k]) $display("FAIL %s_twos: got %0d, want %0d", t_name[k], g_twos, w_twos[k]);
            else passed++;
            checks++;
            if (g_ok !== w_ok[k] || g_err !== !w_ok[k])
                $display("FAIL %s_verdict: got ok=%b err=%b, want ok=%b err=%b", t_name[k], g_ok, g_err, w_ok[k], !w_ok[k]);
            else passed++;
            checks++;
            if (g_done_after !== 1'b0 || g_state_after !== 2'd0)
                $display("FAIL %s_after: got done=%b state=%0d, want 0 0", t_name[k], g_done_after, g_state_after);
            else passed++;
            checks++;
            if (g_ok_after !== w_ok[k] || g_err_after !== !w_ok[k])
                $display("FAIL %s_held: got ok=%b err=%b, want ok=%b err=%b", t_name[k], g_ok_after, g_err_after, w_ok[k], !w_ok[k]);
            else passed++;
        end
    endtask

    task automatic test_restart();
        @(negedge clock);
        start = 1'b1; expected = 5'd20;
        @(negedge clock);
        start = 1'b0; DEZ = 1'b1;
        @(negedge clock);
        @(negedge clock);
        DEZ = 1'b0;
        checks++;
        if (total !== 5'd20) $display("FAIL restart_pre_total: got %0d, want 20", total);
        else passed++;
        start = 1'b1; expected = 5'd4;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (total !== 5'd0 || tens !== 3'd0 || state !== 2'd1)
            $display("FAIL restart_cleared: got total=%0d tens=%0d state=%0d, want 0 0 1", total, tens, state);
        else passed++;
        DOIS = 1'b1;
        @(negedge clock);
        FIM = 1'b1;
        @(negedge clock);
        // start while in CHECK and REPORT must be ignored
        DOIS = 1'b0; FIM = 1'b0; start = 1'b1; expected = 5'd0;
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || ok !== 1'b1 || err !== 1'b0 || total !== 5'd4 || twos !== 4'd2)
            $display("FAIL restart_verdict: got done=%b ok=%b err=%b total=%0d twos=%0d, want 1 1 0 4 2",
                     done, ok, err, total, twos);
        else passed++;
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (state !== 2'd0 || ok !== 1'b1)
            $display("FAIL restart_ignore_start: got state=%0d ok=%b, want 0 1", state, ok);
        else passed++;
    endtask

    task automatic test_timeout();
        int k;
        logic [1:0] st_32;
        @(negedge clock);
        start = 1'b1; expected = 5'd5;
        @(negedge clock);
        start = 1'b0;
        k = 1;
        st_32 = 2'd0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
            if (k == 32) st_32 = state;
        end
        checks++;
        if (st_32 !== 2'd1) $display("FAIL timeout_early: got state=%0d at cycle 32, want 1", st_32);
        else passed++;
        checks++;
        if (k != 33) $display("FAIL timeout_done_cycle: got %0d, want 33", k);
        else passed++;
        checks++;
        if (err !== 1'b1 || ok !== 1'b0) $display("FAIL timeout_verdict: got ok=%b err=%b, want 0 1", ok, err);
        else passed++;
        @(negedge clock);
        checks++;
        if (state !== 2'd0 || done !== 1'b0 || err !== 1'b1)
            $display("FAIL timeout_idle: got state=%0d done=%b err=%b, want 0 0 1", state, done, err);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        @(negedge clock);
        start = 1'b1; expected = 5'd20;
        @(negedge clock);
        start = 1'b0; DEZ = 1'b1;
        repeat (2) @(negedge clock);
        DEZ = 1'b0;
        checks++;
        if (total !== 5'd20 || tens !== 3'd2 || state !== 2'd1)
            $display("FAIL resetmid_pre: got total=%0d tens=%0d state=%0d, want 20 2 1", total, tens, state);
        else passed++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({state, total, tens, twos, done, ok, err} !== 17'd0)
            $display("FAIL resetmid_async: got state=%0d total=%0d tens=%0d twos=%0d done=%b ok=%b err=%b, want all 0",
                     state, total, tens, twos, done, ok, err);
        else passed++;
        FIM = 1'b1;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (done === 1'b1) saw_done = 1'b1;
        end
        reset = 1'b1;
        FIM   = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0 || state !== 2'd0)
            $display("FAIL resetmid_no_done: got done_seen=%b state=%0d, want 0 0", saw_done, state);
        else passed++;
    endtask

    task automatic test_random();
        int n, lat, m_total, m_tens, m_twos;
        logic m_ok, m_ord;
        logic [4:0] exp_v;
        logic [23:0] dz, dw;
        logic [4:0] g_total;
        logic [2:0] g_tens;
        logic [3:0] g_twos;
        logic g_ok, g_err, g_done_after, g_ok_after, g_err_after;
        logic [1:0] g_mid, g_state_after;
        for (int it = 0; it < 40; it++) begin
            n  = $urandom_range(1, 10);
            dz = 24'($urandom) & 24'($urandom) & 24'($urandom);
            dw = 24'($urandom);
            exp_v = 5'($urandom);
            model(n, dz, dw, exp_v, m_total, m_tens, m_twos, m_ok, m_ord);
            if ($urandom_range(0, 1) == 1) begin
                exp_v = 5'(m_total);
                model(n, dz, dw, exp_v, m_total, m_tens, m_twos, m_ok, m_ord);
            end
            drive_collection(exp_v, n, dz, dw, lat, g_total, g_tens, g_twos,
                             g_ok, g_err, g_mid, g_done_after, g_ok_after, g_err_after, g_state_after);
            checks++;
            if (lat != 2 || int'(g_total) != m_total || int'(g_tens) != m_tens || int'(g_twos) != m_twos
                || g_ok !== m_ok || g_err !== !m_ok || g_done_after !== 1'b0 || g_state_after !== 2'd0)
                $display("FAIL random_%0d: got lat=%0d total=%0d tens=%0d twos=%0d ok=%b err=%b done_after=%b state_after=%0d, want lat=2 total=%0d tens=%0d twos=%0d ok=%b err=%b done_after=0 state_after=0 (ord=%b)",
                         it, lat, g_total, g_tens, g_twos, g_ok, g_err, g_done_after, g_state_after,
                         m_total, m_tens, m_twos, m_ok, !m_ok, m_ord);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_restart();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
